// File: rtl/l2_mem_arbiter.sv
// L2 miss/write-back arbiter: serialises inst refills, data refills and
// write-backs onto one valid/ready backing-memory channel.
module l2_mem_arbiter #(
    parameter int DATA_LENGTH  = 32,
    parameter int INST_LENGTH  = 32,
    parameter int PC_LENGTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_read_req,
    input  logic [PC_LENGTH-1:0]   inst_addr,
    output logic                   inst_res,
    output logic [INST_LENGTH-1:0] inst_mem_read,
    input  logic                   data_read_req,
    input  logic                   data_write_req,
    input  logic [DATA_LENGTH-1:0] data_addr,
    input  logic [DATA_LENGTH-1:0] data_mem_write,
    output logic                   data_res,
    output logic [DATA_LENGTH-1:0] data_mem_read,
    output logic                   mem_valid,
    output logic                   mem_we,
    output logic [DATA_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    input  logic                   mem_ready,
    input  logic [DATA_LENGTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        INST_BUSY,
        DATA_RD_BUSY,
        DATA_WR_BUSY,
        RESP
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e                 state_q, state_d;
    logic [3:0]             starve_q, starve_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_we_q, mem_we_d;
    logic [DATA_LENGTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_LENGTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                   inst_res_q, inst_res_d;
    logic                   data_res_q, data_res_d;
    logic [INST_LENGTH-1:0] inst_rd_q, inst_rd_d;
    logic [DATA_LENGTH-1:0] data_rd_q, data_rd_d;
    logic                   starved, gnt_inst, gnt_wr, gnt_rd;

    // A starved inst request overrides the write-first data priority.
    always_comb begin
        starved  = inst_read_req && (starve_q == LIMIT);
        gnt_wr   = !starved && data_write_req;
        gnt_rd   = !starved && !data_write_req && data_read_req;
        gnt_inst = inst_read_req && !gnt_wr && !gnt_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inst_res_q  <= 1'b0;
            data_res_q  <= 1'b0;
            inst_rd_q   <= '0;
            data_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            inst_res_q  <= inst_res_d;
            data_res_q  <= data_res_d;
            inst_rd_q   <= inst_rd_d;
            data_rd_q   <= data_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_inst)    state_d = INST_BUSY;
                else if (gnt_wr) state_d = DATA_WR_BUSY;
                else if (gnt_rd) state_d = DATA_RD_BUSY;
            end
            INST_BUSY, DATA_RD_BUSY, DATA_WR_BUSY: begin
                if (mem_ready) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d    = starve_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        inst_res_d  = 1'b0;
        data_res_d  = 1'b0;
        inst_rd_d   = inst_rd_q;
        data_rd_d   = data_rd_q;
        unique case (state_q)
            IDLE: begin
                if (!inst_read_req) starve_d = '0;
                if (gnt_inst) begin
                    starve_d    = '0;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = DATA_LENGTH'(inst_addr);
                end else if (gnt_wr || gnt_rd) begin
                    mem_valid_d = 1'b1;
                    mem_we_d    = gnt_wr;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_mem_write;
                    if (inst_read_req && starve_q != LIMIT)
                        starve_d = starve_q + 4'd1;
                end
            end
            INST_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    inst_res_d  = 1'b1;
                    inst_rd_d   = mem_rdata[INST_LENGTH-1:0];
                end
            end
            DATA_RD_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    data_res_d  = 1'b1;
                    data_rd_d   = mem_rdata;
                end
            end
            DATA_WR_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    data_res_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_valid     = mem_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign inst_res      = inst_res_q;
    assign data_res      = data_res_q;
    assign inst_mem_read = inst_rd_q;
    assign data_mem_read = data_rd_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_l2_mem_arbiter;

    localparam int DL = 32;
    localparam int IL = 32;
    localparam int PL = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_read_req;
    logic [PL-1:0] inst_addr;
    logic          inst_res;
    logic [IL-1:0] inst_mem_read;
    logic          data_read_req;
    logic          data_write_req;
    logic [DL-1:0] data_addr;
    logic [DL-1:0] data_mem_write;
    logic          data_res;
    logic [DL-1:0] data_mem_read;
    logic          mem_valid;
    logic          mem_we;
    logic [DL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_ready;
    logic [DL-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    l2_mem_arbiter #(
        .DATA_LENGTH (DL),
        .INST_LENGTH (IL),
        .PC_LENGTH   (PL),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_read_req (inst_read_req),
        .inst_addr     (inst_addr),
        .inst_res      (inst_res),
        .inst_mem_read (inst_mem_read),
        .data_read_req (data_read_req),
        .data_write_req(data_write_req),
        .data_addr     (data_addr),
        .data_mem_write(data_mem_write),
        .data_res      (data_res),
        .data_mem_read (data_mem_read),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_read_req  = 1'b0;
        inst_addr      = '0;
        data_read_req  = 1'b0;
        data_write_req = 1'b0;
        data_addr      = '0;
        data_mem_write = '0;
        mem_ready      = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({inst_res, data_res, mem_valid, mem_we, mem_addr, mem_wdata,
             inst_mem_read, data_mem_read} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%h/%h/%h expected all 0",
                     {inst_res, data_res, mem_valid, mem_we}, mem_addr,
                     inst_mem_read, data_mem_read);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({mem_valid, inst_res, data_res} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: got %b expected 000",
                     {mem_valid, inst_res, data_res});
        end
    endtask

    task automatic test_single_inst();
        do_reset();
        inst_read_req = 1'b1;
        inst_addr     = 32'h0000_1000;
        tick();
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            n_err++;
            $display("FAIL inst_grant: got %b/%b/%h expected 1/0/00001000",
                     mem_valid, mem_we, mem_addr);
        end
        tick();
        n_cmp++;
        if ({mem_valid, inst_res, data_res} !== 3'b100) begin
            n_err++;
            $display("FAIL inst_wait: got %b expected 100",
                     {mem_valid, inst_res, data_res});
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_7033;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        n_cmp++;
        if ({inst_res, data_res, mem_valid} !== 3'b100 ||
            inst_mem_read !== 32'h0000_7033) begin
            n_err++;
            $display("FAIL inst_resp: got %b data %h expected 100 data 00007033",
                     {inst_res, data_res, mem_valid}, inst_mem_read);
        end
        inst_read_req = 1'b0;
        tick();
        n_cmp++;
        if ({inst_res, data_res, mem_valid} !== 3'b000 ||
            inst_mem_read !== 32'h0000_7033) begin
            n_err++;
            $display("FAIL inst_after: got %b data %h expected 000 data 00007033",
                     {inst_res, data_res, mem_valid}, inst_mem_read);
        end
    endtask

    task automatic test_write_before_read();
        do_reset();
        data_write_req = 1'b1;
        data_read_req  = 1'b1;
        data_addr      = 32'h0000_0200;
        data_mem_write = 32'hDEAD_BEEF;
        mem_ready      = 1'b1;
        mem_rdata      = 32'h0BAD_F00D;
        tick();
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL wbr_first: got %b/%b/%h/%h expected 1/1/00000200/deadbeef",
                     mem_valid, mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_cmp++;
        if ({data_res, inst_res, mem_valid} !== 3'b100 || data_mem_read !== '0) begin
            n_err++;
            $display("FAIL wbr_wr_resp: got %b data %h expected 100 data 0",
                     {data_res, inst_res, mem_valid}, data_mem_read);
        end
        data_write_req = 1'b0;
        data_addr      = 32'h0000_0300;
        mem_rdata      = 32'hCAFE_0001;
        tick();
        n_cmp++;
        if ({data_res, mem_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL wbr_gap: got %b expected 00", {data_res, mem_valid});
        end
        tick();
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0300}) begin
            n_err++;
            $display("FAIL wbr_second: got %b/%b/%h expected 1/0/00000300",
                     mem_valid, mem_we, mem_addr);
        end
        tick();
        data_read_req = 1'b0;
        mem_ready     = 1'b0;
        n_cmp++;
        if ({data_res, mem_valid} !== 2'b10 || data_mem_read !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL wbr_rd_resp: got %b data %h expected 10 data cafe0001",
                     {data_res, mem_valid}, data_mem_read);
        end
        tick();
        n_cmp++;
        if (data_res !== 1'b0) begin
            n_err++;
            $display("FAIL wbr_end: data_res got %b expected 0", data_res);
        end
    endtask

    task automatic test_starvation();
        int  kinds[$];
        logic pv;
        do_reset();
        pv            = 1'b0;
        inst_addr     = 32'h0000_AAA0;
        data_addr     = 32'h0000_BBB0;
        inst_read_req = 1'b1;
        data_read_req = 1'b1;
        mem_ready     = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            mem_rdata = $urandom;
            if (mem_valid && !pv) kinds.push_back(mem_addr == 32'h0000_AAA0 ? 1 : 0);
            pv = mem_valid;
            inst_read_req = !inst_res;
        end
        n_cmp++;
        if (kinds.size() < 10) begin
            n_err++;
            $display("FAIL starve_count: got %0d grants expected >= 10", kinds.size());
        end
        for (int i = 0; i < 10 && i < kinds.size(); i++) begin
            n_cmp++;
            if (kinds[i] !== ((i % 5 == 4) ? 1 : 0)) begin
                n_err++;
                $display("FAIL starve_grant%0d: got inst=%0d expected inst=%0d",
                         i, kinds[i], (i % 5 == 4) ? 1 : 0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        data_write_req = 1'b1;
        data_addr      = 32'h0000_0044;
        data_mem_write = 32'h1234_5678;
        tick();
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL stall_grant: got %b/%b/%h/%h expected 1/1/00000044/12345678",
                     mem_valid, mem_we, mem_addr, mem_wdata);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                data_write_req = 1'b0;
                data_addr      = 32'hFFFF_0000;
                data_mem_write = 32'h0000_FFFF;
            end
            tick();
            n_cmp++;
            if ({mem_valid, mem_we, mem_addr, mem_wdata, data_res} !==
                {1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got %b/%b/%h/%h res %b expected stable",
                         k, mem_valid, mem_we, mem_addr, mem_wdata, data_res);
            end
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if ({data_res, mem_valid} !== 2'b10 || data_mem_read !== '0) begin
            n_err++;
            $display("FAIL stall_resp: got %b data %h expected 10 data 0",
                     {data_res, mem_valid}, data_mem_read);
        end
        tick();
        tick();
        n_cmp++;
        if ({data_res, mem_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_end: got %b expected 00", {data_res, mem_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        seen          = 1'b0;
        data_read_req = 1'b1;
        data_addr     = 32'h0000_0080;
        tick();
        n_cmp++;
        if ({mem_valid, mem_we} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_busy: got %b expected 10", {mem_valid, mem_we});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: mem_valid got %b expected 0", mem_valid);
        end
        data_read_req = 1'b0;
        mem_ready     = 1'b1;
        mem_rdata     = 32'h1111_2222;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (data_res || inst_res || mem_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet: activity got %b expected 0", seen);
        end
        inst_read_req = 1'b1;
        inst_addr     = 32'h0000_1234;
        mem_rdata     = 32'h0000_55AA;
        tick();
        n_cmp++;
        if ({mem_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_1234}) begin
            n_err++;
            $display("FAIL rstmid_inst_grant: got %b/%b/%h expected 1/0/00001234",
                     mem_valid, mem_we, mem_addr);
        end
        tick();
        inst_read_req = 1'b0;
        mem_ready     = 1'b0;
        n_cmp++;
        if ({inst_res, data_res} !== 2'b10 || inst_mem_read !== 32'h0000_55AA) begin
            n_err++;
            $display("FAIL rstmid_inst_resp: got %b data %h expected 10 data 000055aa",
                     {inst_res, data_res}, inst_mem_read);
        end
        tick();
    endtask

    task automatic test_idle_spurious();
        logic seen;
        do_reset();
        seen      = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = $urandom;
            tick();
            if (mem_valid || inst_res || data_res) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || inst_mem_read !== '0 || data_mem_read !== '0) begin
            n_err++;
            $display("FAIL idle_spurious: activity %b data %h/%h expected 0",
                     seen, inst_mem_read, data_mem_read);
        end
        mem_ready = 1'b0;
    endtask

    // Transaction-level model: one outstanding memory transaction, a
    // response cycle after acceptance, then free to grant again.
    task automatic test_random();
        logic          m_busy, m_resp, e_ires, e_dres;
        int            m_kind, r_kind, starve, pick, n_resp;
        logic [DL-1:0] m_addr, m_wdata, e_drd;
        logic [IL-1:0] e_ird;
        logic          p_inst, p_rd, p_wr, p_ready;
        logic [PL-1:0] p_iaddr, ia;
        logic [DL-1:0] p_daddr, p_wdata, p_rdata, ra, wa, wd;
        logic          i_pend, r_pend, w_pend;
        do_reset();
        m_busy = 0; m_resp = 0; m_kind = 0; r_kind = 0; starve = 0;
        n_resp = 0; m_addr = '0; m_wdata = '0; e_drd = '0; e_ird = '0;
        p_inst = 0; p_rd = 0; p_wr = 0; p_ready = 0;
        p_iaddr = '0; p_daddr = '0; p_wdata = '0; p_rdata = '0;
        i_pend = 0; r_pend = 0; w_pend = 0;
        ia = '0; ra = '0; wa = '0; wd = '0;
        for (int c = 0; c < 800; c++) begin
            if (m_resp) begin
                m_resp = 0;
            end else if (m_busy) begin
                if (p_ready) begin
                    m_busy = 0;
                    m_resp = 1;
                    r_kind = m_kind;
                    if (m_kind == 0) e_ird = p_rdata[IL-1:0];
                    if (m_kind == 1) e_drd = p_rdata;
                end
            end else begin
                pick = -1;
                if (!p_inst) starve = 0;
                if (p_inst && starve == SL) pick = 0;
                else if (p_wr)              pick = 2;
                else if (p_rd)              pick = 1;
                else if (p_inst)            pick = 0;
                if (pick == 0) starve = 0;
                else if (pick > 0 && p_inst && starve < SL) starve++;
                if (pick >= 0) begin
                    m_busy  = 1;
                    m_kind  = pick;
                    m_addr  = (pick == 0) ? DL'(p_iaddr) : p_daddr;
                    m_wdata = p_wdata;
                end
            end
            e_ires = m_resp && r_kind == 0;
            e_dres = m_resp && r_kind != 0;
            n_cmp++;
            if (mem_valid !== m_busy) begin
                n_err++;
                $display("FAIL rnd_valid c%0d: got %b expected %b", c, mem_valid, m_busy);
            end
            if (m_busy) begin
                n_cmp++;
                if ({mem_we, mem_addr} !== {(m_kind == 2), m_addr}) begin
                    n_err++;
                    $display("FAIL rnd_req c%0d: got %b/%h expected %b/%h",
                             c, mem_we, mem_addr, m_kind == 2, m_addr);
                end
                if (m_kind == 2) begin
                    n_cmp++;
                    if (mem_wdata !== m_wdata) begin
                        n_err++;
                        $display("FAIL rnd_wdata c%0d: got %h expected %h",
                                 c, mem_wdata, m_wdata);
                    end
                end
            end
            n_cmp++;
            if ({inst_res, data_res} !== {e_ires, e_dres}) begin
                n_err++;
                $display("FAIL rnd_res c%0d: got %b%b expected %b%b",
                         c, inst_res, data_res, e_ires, e_dres);
            end
            n_cmp++;
            if (inst_mem_read !== e_ird || data_mem_read !== e_drd) begin
                n_err++;
                $display("FAIL rnd_rdata c%0d: got %h/%h expected %h/%h",
                         c, inst_mem_read, data_mem_read, e_ird, e_drd);
            end
            if (m_resp) n_resp++;
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1; ia = $urandom;
            end
            if (!r_pend && $urandom_range(2) == 0) begin
                r_pend = 1; ra = $urandom;
            end
            if (!w_pend && $urandom_range(3) == 0) begin
                w_pend = 1; wa = $urandom; wd = $urandom;
            end
            if (e_ires) i_pend = 0;
            if (e_dres && r_kind == 1) r_pend = 0;
            if (e_dres && r_kind == 2) w_pend = 0;
            inst_read_req  = i_pend;
            inst_addr      = ia;
            data_read_req  = r_pend;
            data_write_req = w_pend;
            data_addr      = w_pend ? wa : ra;
            data_mem_write = wd;
            mem_ready      = ($urandom_range(1) == 0);
            mem_rdata      = $urandom;
            p_inst  = inst_read_req;
            p_rd    = data_read_req;
            p_wr    = data_write_req;
            p_iaddr = inst_addr;
            p_daddr = data_addr;
            p_wdata = data_mem_write;
            p_ready = mem_ready;
            p_rdata = mem_rdata;
            tick();
        end
        n_cmp++;
        if (n_resp < 50) begin
            n_err++;
            $display("FAIL rnd_progress: got %0d responses expected >= 50", n_resp);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_inst();
        test_write_before_read();
        test_starvation();
        test_stall();
        test_reset_mid();
        test_idle_spurious();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Sits between the L2 cache's miss/write-back port and single-port backing memory. It carries L2's instruction-read, data-read and data-write requests.
- Serialises these onto one memory request channel with a valid/ready handshake. Returns per-source response pulses (inst_res, data_res) together with read data.
- Provides write-before-read ordering and a starvation guard for instruction refills.

Parameters:
- DATA_LENGTH, 32, data bus width
- INST_LENGTH, 32, instruction word width
- PC_LENGTH, 32, instruction address width
- STARVE_LIMIT, 4, consecutive data grants allowed while an inst request waits (range 1-15)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- inst_read_req  input  1  L2 instruction refill request (level, held until inst_res)
- inst_addr  input  PC_LENGTH  instruction refill address
- inst_res  output  1  one-cycle completion pulse for instruction read
- inst_mem_read  output  INST_LENGTH  instruction read data, valid with inst_res
- data_read_req  input  1  L2 data refill request (level)
- data_write_req  input  1  L2 write-back request (level)
- data_addr  input  DATA_LENGTH  data address
- data_mem_write  input  DATA_LENGTH  write-back data
- data_res  output  1  one-cycle completion pulse for data read or write
- data_mem_read  output  DATA_LENGTH  data read data, valid with data_res
- mem_valid  output  1  request to backing memory
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  DATA_LENGTH  memory address (inst_addr zero-extended)
- mem_wdata  output  DATA_LENGTH  memory write data
- mem_ready  input  1  memory accepts/completes current request; mem_rdata valid same cycle
- mem_rdata  input  DATA_LENGTH  memory read data

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0. Asserting rst_n low mid-transaction drops mem_valid immediately and discards the transaction. No response pulse is issued for it.
- FSM states: IDLE, INST_BUSY, DATA_RD_BUSY, DATA_WR_BUSY, RESP.
- IDLE arbitration order:
  - If inst_read_req is pending and starve_cnt == STARVE_LIMIT, grant inst.
  - Else data_write_req, then data_read_req, then inst_read_req.
  - Simultaneous data write and read: write first, so a dirty-line write-back precedes the refill.
- Grant (cycle N, IDLE): latch address, wdata and mem_we into output registers. mem_valid = 1 from cycle N+1. Move to the matching BUSY state.
- BUSY: mem_valid, mem_we, mem_addr and mem_wdata stay stable until a cycle M with mem_ready = 1.
  - At M, capture mem_rdata (reads only) and go to RESP.
  - mem_valid is 0 from M+1.
- RESP (cycle M+1):
  - Pulse exactly one of inst_res/data_res for one cycle.
  - inst_mem_read = mem_rdata[INST_LENGTH-1:0] for instruction reads; data_mem_read = mem_rdata for data reads.
  - Read data outputs hold their value until the next read response on the same port. Write completion leaves data_mem_read unchanged.
  - Return to IDLE. Requests are not sampled in RESP; the source must deassert its request the cycle after its res pulse.
  - Minimum request-to-response time is 3 cycles (grant, mem_valid with mem_ready, RESP).
- starve_cnt:
  - Cleared on every inst grant, and whenever inst_read_req = 0 in IDLE.
  - Incremented (saturating at STARVE_LIMIT) on each data grant made while inst_read_req = 1.
- mem_ready while mem_valid = 0 is ignored.
- A request dropped mid-BUSY has no effect: the transaction completes and the response pulse is still issued.
- No back-to-back grants: at most one transaction in flight.

Test Plan:
- Single inst read: inst_read_req = 1, inst_addr = 0x0000_1000; mem_ready after 2 cycles with mem_rdata = 0x0000_7033 -> mem_valid/mem_we = 1/0, mem_addr 0x1000; inst_res pulses one cycle with inst_mem_read = 0x0000_7033; data_res stays 0.
- Write-before-read: data_write_req and data_read_req raised together, addr 0x200, wdata 0xDEAD_BEEF; L2 deasserts each request after its pulse and presents read addr 0x300 after the write pulse -> first transaction mem_we = 1, addr 0x200, wdata 0xDEAD_BEEF; second mem_we = 0, addr 0x300; two data_res pulses separated by ≥3 cycles.
- Starvation guard: STARVE_LIMIT = 4, inst_read_req held, data_read_req re-asserted continuously, mem_ready = 1 immediately -> exactly 4 data grants, then inst grant, then starve_cnt = 0.
- Stall stability: mem_ready held 0 for 10 cycles during a data write -> mem_valid, mem_addr and mem_wdata constant all 10 cycles; single data_res only after mem_ready.
- Reset mid-transaction: rst_n low while in DATA_RD_BUSY -> mem_valid = 0 immediately; no data_res after release; next inst request served normally from IDLE.
- Idle/spurious: mem_ready = 1 with no requests -> no res pulses, mem_valid remains 0.
